life_controller: RTL
====================

# life_controller

Sequential game-state controller for the player's lives HUD. Turns raw crush events from collision detection into life decrements, with a frame-counted invincibility window after each hit. Runs the game-over/retry sequence. Drives the heart mask, lives count, dead flag and restart pulse consumed by the HUD sprite renderer and the game core. The block sits between the collision logic and the HUD/scene renderers, and all of its timing is in frames counted from `i_v_sync`.

## Interface
Parameters:
- `LIVES`, 3: lives at reset and after restart; legal range 1..3.
- `GRACE_FRAMES`, 60: invincibility frames after a hit or restart; legal range 1..255.
- `BLINK_FRAMES`, 8: frames per `o_blink` half-period during grace; legal range 1..255.
- `DEAD_HOLD_FRAMES`, 30: minimum frames in DEAD before retry is accepted; legal range 1..255.

Ports:
- `i_clk`  in  1  pixel/system clock; the only clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_v_sync`  in  1  vertical sync level; its rising edge is the frame tick.
- `i_crushed`  in  1  collision level from the game core; asynchronous to `i_clk`.
- `i_retry`  in  1  retry button level; asynchronous to `i_clk`.
- `o_lives`  out  2  remaining lives, 0..LIVES.
- `o_heart_mask`  out  3  bit k = 1 means heart k+1 is drawn filled (k=0 is leftmost).
- `o_invincible`  out  1  high while in GRACE.
- `o_blink`  out  1  player-sprite visibility strobe.
- `o_is_dead`  out  1  high in DEAD; enables the RETRY banner.
- `o_restart`  out  1  one-cycle pulse when a game restarts.

## Operation
- Synchronisers: `i_v_sync`, `i_crushed` and `i_retry` each pass through 2-FF synchronisers. A rising-edge detector on each synced signal gives one-cycle `frame_tick`, `crush_evt` and `retry_evt`.
- States: ALIVE, GRACE, DEAD. Reset state is ALIVE.
- **ALIVE**
  - On `crush_evt` with `lives > 1`: decrement `lives`, clear the grace counter, set `o_blink` to 1, enter GRACE.
  - On `crush_evt` with `lives == 1`: set `lives` to 0, clear the hold counter, enter DEAD.
- **GRACE**
  - `crush_evt` is ignored.
  - Each `frame_tick` increments `grace_cnt` (8-bit).
  - `o_blink` toggles whenever `blink_cnt` reaches BLINK_FRAMES; `blink_cnt` then resets to 0.
  - When a `frame_tick` brings `grace_cnt` to GRACE_FRAMES: enter ALIVE and set `o_blink` to 1.
- **DEAD**
  - `crush_evt` is ignored.
  - `hold_cnt` increments on each `frame_tick` and saturates at DEAD_HOLD_FRAMES.
  - `retry_evt` is accepted only when `hold_cnt == DEAD_HOLD_FRAMES`. On acceptance: pulse `o_restart`, load `lives` with LIVES, clear counters, set `o_blink` to 1, enter GRACE (spawn protection).
  - `retry_evt` arriving before that point is discarded, not queued.
- Outputs are registered.
  - `o_heart_mask[k] = (lives > k)`.
  - `o_is_dead = (state == DEAD)`.
  - `o_invincible = (state == GRACE)`.
  - `o_blink` is 1 in ALIVE and 0 in DEAD.
- Width rules: counters are 8 bits; `lives` is 2 bits and is never decremented below 0.

## Timing
- Reset values:
  - `o_lives = LIVES`.
  - `o_heart_mask = (1<<LIVES)-1`, i.e. 3'b111 for the default.
  - `o_blink = 1`.
  - `o_invincible = 0`, `o_is_dead = 0`, `o_restart = 0`.
  - All counters and synchroniser flops are 0.
- Latency: an input level first sampled high at edge N produces its event pulse in cycle N+2. State and outputs update at edge N+3.
- Crush and frame tick in the same cycle:
  - In ALIVE, the crush is taken.
  - In GRACE, the crush is ignored even if that tick ends grace.
- Retry and the frame tick that completes the hold in the same cycle: retry is rejected, because `hold_cnt` had not yet reached the limit.
- `i_crushed` held high produces one event only; it must fall and rise again to produce another.
- `i_rst_n` asserted mid-grace or in DEAD returns all outputs to their reset values immediately (asynchronously), with no `o_restart` pulse.
- Deassertion of `i_rst_n` is synchronised inside the block before it releases the state flops.

## Test plan
- After reset: `o_lives=3`, `o_heart_mask=3'b111`, `o_blink=1`, `o_is_dead=0`. Raise `i_crushed` -> exactly 3 clocks later `o_lives=2`, mask `3'b011`, `o_invincible=1`.
- In GRACE (default parameters), pulse `i_crushed` 5 times -> `o_lives` stays 2. After 60 `i_v_sync` rising edges, `o_invincible=0`. `o_blink` toggles every 8 frames (7 toggles) and ends at 1.
- Three separated crushes -> after the third, `o_lives=0`, mask `3'b000`, `o_is_dead=1`. Pulse `i_retry` at frame 10 -> no effect. Pulse at frame 31 -> `o_restart` high exactly 1 cycle, `o_lives=3`, `o_invincible=1`, `o_is_dead=0`.
- With `LIVES=1`, one crush -> DEAD directly; no GRACE entered.
- Crush coincident with the 60th grace frame tick -> lives unchanged, state ALIVE. A crush one cycle later -> decrement.
- Assert `i_rst_n=0` in DEAD at frame 12 -> outputs at reset values within the same cycle, and `o_restart` never pulses.

Source files
------------

// File: rtl/life_controller.sv
// life_controller: lives, invincibility window and game-over/retry sequencing for the HUD, timed in v_sync frames
module life_controller #(
  parameter int LIVES            = 3,
  parameter int GRACE_FRAMES     = 60,
  parameter int BLINK_FRAMES     = 8,
  parameter int DEAD_HOLD_FRAMES = 30
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_v_sync,
  input  logic       i_crushed,
  input  logic       i_retry,
  output logic [1:0] o_lives,
  output logic [2:0] o_heart_mask,
  output logic       o_invincible,
  output logic       o_blink,
  output logic       o_is_dead,
  output logic       o_restart
);
  typedef enum logic [1:0] {ALIVE, GRACE, DEAD} state_t;
  localparam logic [1:0] L_INIT = 2'(LIVES);
  localparam logic [2:0] M_INIT = 3'((1 << LIVES) - 1);
  localparam logic [7:0] G_MAX  = 8'(GRACE_FRAMES);
  localparam logic [7:0] B_MAX  = 8'(BLINK_FRAMES);
  localparam logic [7:0] H_MAX  = 8'(DEAD_HOLD_FRAMES);
  logic [1:0] r_rst_sync;
  logic       w_rst_n;
  logic [2:0] r_vs, r_cr, r_rt;
  logic       r_tick, r_crush, r_retry;
  state_t     r_state, w_state_nxt;
  logic [1:0] r_lives, w_lives_nxt;
  logic [7:0] r_grace, w_grace_nxt, r_bcnt, w_bcnt_nxt, r_hold, w_hold_nxt;
  logic       r_blink, w_blink_nxt, r_restart, w_restart_nxt;
  logic [2:0] r_mask, w_mask_nxt;
  logic       r_inv, w_inv_nxt, r_dead, w_dead_nxt;
  logic       w_grace_done, w_bwrap, w_accept;
  // reset asserts immediately but releases only after two clean clock edges
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_rst_sync <= '0;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  assign w_rst_n = r_rst_sync[1];
  always_ff @(posedge i_clk or negedge w_rst_n)
    if (!w_rst_n) begin
      r_vs    <= '0;
      r_cr    <= '0;
      r_rt    <= '0;
      r_tick  <= 1'b0;
      r_crush <= 1'b0;
      r_retry <= 1'b0;
    end else begin
      r_vs    <= {r_vs[1:0], i_v_sync};
      r_cr    <= {r_cr[1:0], i_crushed};
      r_rt    <= {r_rt[1:0], i_retry};
      r_tick  <= r_vs[1] & ~r_vs[2];
      r_crush <= r_cr[1] & ~r_cr[2];
      r_retry <= r_rt[1] & ~r_rt[2];
    end
  always_ff @(posedge i_clk or negedge w_rst_n)
    if (!w_rst_n) begin
      r_state   <= ALIVE;
      r_lives   <= L_INIT;
      r_grace   <= '0;
      r_bcnt    <= '0;
      r_hold    <= '0;
      r_blink   <= 1'b1;
      r_restart <= 1'b0;
      r_mask    <= M_INIT;
      r_inv     <= 1'b0;
      r_dead    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lives   <= w_lives_nxt;
      r_grace   <= w_grace_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_hold    <= w_hold_nxt;
      r_blink   <= w_blink_nxt;
      r_restart <= w_restart_nxt;
      r_mask    <= w_mask_nxt;
      r_inv     <= w_inv_nxt;
      r_dead    <= w_dead_nxt;
    end
  // hold is compared before this tick's increment, so a retry on the completing tick is rejected
  assign w_grace_done = r_tick && (r_grace + 8'd1 == G_MAX);
  assign w_bwrap      = r_bcnt + 8'd1 == B_MAX;
  assign w_accept     = r_retry && r_hold == H_MAX;
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ALIVE:   w_state_nxt = r_crush ? ((r_lives > 2'd1) ? GRACE : DEAD) : ALIVE;
      GRACE:   w_state_nxt = w_grace_done ? ALIVE : GRACE;
      DEAD:    w_state_nxt = w_accept ? GRACE : DEAD;
      default: w_state_nxt = ALIVE;
    endcase
  end
  always_comb begin
    w_lives_nxt   = r_lives;
    w_grace_nxt   = r_grace;
    w_bcnt_nxt    = r_bcnt;
    w_hold_nxt    = r_hold;
    w_blink_nxt   = r_blink;
    w_restart_nxt = 1'b0;
    case (r_state)
      ALIVE: begin
        w_blink_nxt = 1'b1;
        if (r_crush) begin
          w_lives_nxt = (r_lives > 2'd1) ? r_lives - 2'd1 : 2'd0;
          w_grace_nxt = '0;
          w_bcnt_nxt  = '0;
          w_hold_nxt  = '0;
          w_blink_nxt = r_lives > 2'd1;
        end
      end
      GRACE: begin
        if (r_tick) begin
          w_grace_nxt = r_grace + 8'd1;
          w_bcnt_nxt  = w_bwrap ? 8'd0 : r_bcnt + 8'd1;
          w_blink_nxt = w_grace_done ? 1'b1 : r_blink ^ w_bwrap;
        end
      end
      DEAD: begin
        w_blink_nxt = 1'b0;
        if (r_tick && r_hold != H_MAX) w_hold_nxt = r_hold + 8'd1;
        if (w_accept) begin
          w_lives_nxt   = L_INIT;
          w_grace_nxt   = '0;
          w_bcnt_nxt    = '0;
          w_hold_nxt    = '0;
          w_blink_nxt   = 1'b1;
          w_restart_nxt = 1'b1;
        end
      end
      default: w_blink_nxt = 1'b1;
    endcase
  end
  always_comb begin
    w_mask_nxt = {w_lives_nxt > 2'd2, w_lives_nxt > 2'd1, w_lives_nxt > 2'd0};
    w_inv_nxt  = w_state_nxt == GRACE;
    w_dead_nxt = w_state_nxt == DEAD;
  end
  assign o_lives      = r_lives;
  assign o_heart_mask = r_mask;
  assign o_invincible = r_inv;
  assign o_blink      = r_blink;
  assign o_is_dead    = r_dead;
  assign o_restart    = r_restart;
endmodule
